dijkstra_sssp_engine: RTL and testbench
=======================================

Name: dijkstra_sssp_engine

Overview:
- Parametrised single-source shortest-path engine, successor to the fixed HLS dijkstra component.
- Reads an N_NODES x N_NODES adjacency matrix from memory over one Avalon-MM master, runs O(N^2) Dijkstra with on-chip distance/visited arrays, then writes the distance vector back to memory.
- Adds a result pointer, true Avalon waitrequest/readdatavalid support, saturating arithmetic and an error return; call/return handshake unchanged.

Parameters:
- N_NODES, 16, number of graph nodes (2..256).
- DIST_W, 32, weight/distance width; also avmm data width.
- ADDR_W, 64, avmm byte-address width.
- IDX_W, $clog2(N_NODES), node index width (derived, not overridable).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  call valid.
- busy  out  1  call stall; high while a call is in progress.
- done  out  1  return valid.
- stall  in  1  return stall from consumer.
- err  out  1  return status; valid with done.
- graph  in  ADDR_W  byte base of matrix; row-major, word (u,v) at graph + (u*N_NODES+v)*(DIST_W/8).
- result  in  ADDR_W  byte base of output; dist[v] at result + v*(DIST_W/8).
- src  in  32  source node index.
- avmm_0_rw_address  out  ADDR_W  byte address.
- avmm_0_rw_byteenable  out  DIST_W/8  all ones whenever read or write is high.
- avmm_0_rw_read  out  1  read request.
- avmm_0_rw_readdata  in  DIST_W  read data.
- avmm_0_rw_readdatavalid  in  1  read data valid.
- avmm_0_rw_waitrequest  in  1  slave not ready; hold request.
- avmm_0_rw_write  out  1  write request.
- avmm_0_rw_writedata  out  DIST_W  write data.

Behaviour:
- Reset: state IDLE; busy=0, done=0, err=0, read=0, write=0, address=0, writedata=0. Reset mid-call aborts immediately, no further bus traffic; arrays need not be cleared.
- Weight encoding: 0 off-diagonal = no edge; diagonal ignored. INF = all ones. Unreachable nodes report INF.
- IDLE: start sampled only when busy=0; graph/result/src latched on acceptance; busy=1 the next cycle. src >= N_NODES -> DONE with err=1, no bus traffic.
- INIT (1 cycle): dist[*]=INF, dist[src]=0, visited[*]=0.
- SELECT (N_NODES cycles): linear scan for minimum dist among unvisited nodes; ties go to lowest index. If no unvisited node or min == INF -> WRITEBACK; else mark u visited -> RELAX.
- RELAX: for v = 0..N_NODES-1; skip (1 cycle, no read) if visited[v] or v == u. Otherwise assert read with the (u,v) address, hold until waitrequest=0, then deassert read and wait for readdatavalid. Only one read outstanding. If w != 0 and dist[u]+w < dist[v], update dist[v]. Sum is computed at DIST_W+1 bits; if the sum >= INF there is no update (saturating). After v = N_NODES-1 -> SELECT.
- WRITEBACK: v = 0..N_NODES-1; assert write with dist[v], hold address/writedata/write until waitrequest=0, next word on the following cycle. Then -> DONE.
- DONE: done=1 and err valid; held while stall=1. On a cycle with done=1 and stall=0 -> IDLE; done, busy and err drop the next cycle.
- read and write are never high in the same cycle. readdatavalid outside RELAX-wait is ignored.
- Latency, zero-wait memory, 1-cycle readdatavalid: bounded by 2 + N*(N + N*3) + N + 1 cycles.

Test Plan:
- N_NODES=4; edges 0->1=4, 0->2=1, 2->1=2, 1->3=5; src=0 -> memory at result = [0,3,1,8], err=0, done for exactly 1 cycle with stall=0.
- Same graph, src=3 -> result = [FFFFFFFF,FFFFFFFF,FFFFFFFF,0]; exactly 3 matrix reads issued (row 3, v != 3).
- src=5 -> done with err=1; zero avmm read/write cycles observed.
- Edges 0->1=FFFFFFF0, 1->2=20; src=0 -> dist[1]=FFFFFFF0, dist[2]=FFFFFFFF (saturated, no wrap to 0x10).
- Random waitrequest (50%) and readdatavalid delay 1-5 cycles -> results identical to zero-wait run; address/writedata stable while waitrequest=1.
- stall=1 for 10 cycles at done -> done stays high and busy stays high; start pulses are ignored. Reset asserted mid-RELAX -> next cycle read=0, busy=0, done=0.

Source files
------------

// File: rtl/dijkstra_sssp_engine.sv
// Single-source shortest-path engine.
// The engine reads an N_NODES x N_NODES weight matrix over one Avalon-MM master,
// runs O(N^2) Dijkstra with on-chip distance and visited arrays, and writes the
// distance vector back to memory.
//
// Handshakes:
//   call   : start is accepted on any cycle where busy=0. graph/result/src are
//            captured on that cycle. busy rises the next cycle and stays high
//            until the return has been taken.
//   return : done=1 (with err valid) holds while stall=1. A cycle with done=1
//            and stall=0 completes the return; done/busy/err drop the next cycle.
//   avmm   : read/write are held with a stable address and writedata until a
//            cycle with waitrequest=0. At most one read is outstanding. After
//            the read is accepted, read drops and the engine waits for
//            readdatavalid. read and write are never high together.
module dijkstra_sssp_engine #(
  parameter int N_NODES = 16,
  parameter int DIST_W  = 32,
  parameter int ADDR_W  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  stall,
  output logic                  err,
  input  logic [ADDR_W-1:0]     graph,
  input  logic [ADDR_W-1:0]     result,
  input  logic [31:0]           src,
  output logic [ADDR_W-1:0]     avmm_0_rw_address,
  output logic [DIST_W/8-1:0]   avmm_0_rw_byteenable,
  output logic                  avmm_0_rw_read,
  input  logic [DIST_W-1:0]     avmm_0_rw_readdata,
  input  logic                  avmm_0_rw_readdatavalid,
  input  logic                  avmm_0_rw_waitrequest,
  output logic                  avmm_0_rw_write,
  output logic [DIST_W-1:0]     avmm_0_rw_writedata
);

  localparam int                IDX_W = $clog2(N_NODES);
  localparam int                BYTES = DIST_W / 8;
  localparam logic [DIST_W-1:0] INF   = {DIST_W{1'b1}};
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_NODES - 1);

  // S_RELAX issues the (u,v) read, or skips v in one cycle.
  // S_RWAIT waits for the read data.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SELECT = 3'd2,
    S_RELAX  = 3'd3,
    S_RWAIT  = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_graph;
  logic [ADDR_W-1:0]   r_result;
  logic [IDX_W-1:0]    r_src;
  logic                r_err;
  logic [IDX_W-1:0]    r_v;          // shared scan index for SELECT/RELAX/WB
  logic [IDX_W-1:0]    r_u;          // node being relaxed
  logic [DIST_W-1:0]   r_du;         // dist[u], frozen once u is visited
  logic                r_found;      // SELECT has seen an unvisited node
  logic [DIST_W-1:0]   r_min;
  logic [IDX_W-1:0]    r_min_idx;
  logic [DIST_W-1:0]   r_dist [N_NODES];
  logic [N_NODES-1:0]  r_visited;

  logic                w_v_last;
  logic                w_src_bad;
  logic [DIST_W-1:0]   w_dist_v;
  logic                w_sel_take;
  logic                w_fin_found;
  logic [DIST_W-1:0]   w_fin_min;
  logic [IDX_W-1:0]    w_fin_idx;
  logic                w_sel_go;
  logic                w_skip;
  logic [DIST_W:0]     w_sum;
  logic                w_upd;
  logic                w_adv;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W-1:0]   w_wr_addr;

  assign w_v_last  = (r_v == LAST);
  assign w_src_bad = (src >= 32'(N_NODES));
  assign w_dist_v  = r_dist[r_v];

  // Running minimum; strict '<' keeps the lowest index on ties.
  assign w_sel_take  = !r_visited[r_v] && (!r_found || (w_dist_v < r_min));
  assign w_fin_found = r_found || w_sel_take;
  assign w_fin_min   = w_sel_take ? w_dist_v : r_min;
  assign w_fin_idx   = w_sel_take ? r_v : r_min_idx;
  assign w_sel_go    = w_fin_found && (w_fin_min != INF);

  // u itself is already visited, so this also covers v == u.
  assign w_skip = r_visited[r_v] || (r_v == r_u);

  // One extra bit so a sum reaching INF is seen rather than wrapping.
  assign w_sum = {1'b0, r_du} + {1'b0, avmm_0_rw_readdata};
  assign w_upd = (avmm_0_rw_readdata != '0) &&
                 (w_sum < {1'b0, INF}) &&
                 (w_sum[DIST_W-1:0] < w_dist_v);

  assign w_adv = (r_state == S_SELECT) ||
                 ((r_state == S_RELAX) && w_skip) ||
                 ((r_state == S_RWAIT) && avmm_0_rw_readdatavalid) ||
                 ((r_state == S_WB) && !avmm_0_rw_waitrequest);

  assign w_rd_addr = r_graph +
                     (ADDR_W'(r_u) * ADDR_W'(N_NODES) + ADDR_W'(r_v)) * ADDR_W'(BYTES);
  assign w_wr_addr = r_result + ADDR_W'(r_v) * ADDR_W'(BYTES);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = w_src_bad ? S_DONE : S_INIT;
      S_INIT:   w_state_nxt = S_SELECT;
      S_SELECT: if (w_v_last) w_state_nxt = w_sel_go ? S_RELAX : S_WB;
      S_RELAX: begin
        if (w_skip) begin
          if (w_v_last) w_state_nxt = S_SELECT;
        end else if (!avmm_0_rw_waitrequest) begin
          w_state_nxt = S_RWAIT;
        end
      end
      S_RWAIT:  if (avmm_0_rw_readdatavalid) w_state_nxt = w_v_last ? S_SELECT : S_RELAX;
      S_WB:     if (!avmm_0_rw_waitrequest && w_v_last) w_state_nxt = S_DONE;
      S_DONE:   if (!stall) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from state and the current scan position.
  always_comb begin
    busy                 = 1'b1;
    done                 = 1'b0;
    err                  = 1'b0;
    avmm_0_rw_read       = 1'b0;
    avmm_0_rw_write      = 1'b0;
    avmm_0_rw_address    = '0;
    avmm_0_rw_writedata  = '0;
    avmm_0_rw_byteenable = '0;
    case (r_state)
      S_IDLE: busy = 1'b0;
      S_RELAX: begin
        if (!w_skip) begin
          avmm_0_rw_read       = 1'b1;
          avmm_0_rw_address    = w_rd_addr;
          avmm_0_rw_byteenable = '1;
        end
      end
      S_WB: begin
        avmm_0_rw_write      = 1'b1;
        avmm_0_rw_address    = w_wr_addr;
        avmm_0_rw_writedata  = w_dist_v;
        avmm_0_rw_byteenable = '1;
      end
      S_DONE: begin
        done = 1'b1;
        err  = r_err;
      end
      default: ;
    endcase
  end

  // Call arguments, scan index and SELECT bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_graph   <= '0;
      r_result  <= '0;
      r_src     <= '0;
      r_err     <= 1'b0;
      r_v       <= '0;
      r_u       <= '0;
      r_du      <= '0;
      r_found   <= 1'b0;
      r_min     <= '0;
      r_min_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_graph  <= graph;
            r_result <= result;
            r_src    <= IDX_W'(src);
            r_err    <= w_src_bad;
          end
        end
        S_INIT: begin
          r_v     <= '0;
          r_found <= 1'b0;
        end
        S_SELECT: begin
          if (w_v_last) begin
            r_found <= 1'b0;
            r_u     <= w_fin_idx;
            r_du    <= w_fin_min;
          end else if (w_sel_take) begin
            r_found   <= 1'b1;
            r_min     <= w_dist_v;
            r_min_idx <= r_v;
          end
        end
        default: ;
      endcase
      if (w_adv) r_v <= w_v_last ? '0 : r_v + 1'b1;
    end
  end

  // Distance and visited arrays; contents are don't-care outside a call.
  always_ff @(posedge clock) begin
    if (r_state == S_INIT) begin
      for (int i = 0; i < N_NODES; i++) r_dist[i] <= INF;
      r_dist[r_src] <= '0;
      r_visited     <= '0;
    end else if ((r_state == S_SELECT) && w_v_last && w_sel_go) begin
      r_visited[w_fin_idx] <= 1'b1;
    end else if ((r_state == S_RWAIT) && avmm_0_rw_readdatavalid && w_upd) begin
      r_dist[r_v] <= w_sum[DIST_W-1:0];
    end
  end

endmodule

// File: tb/tb_dijkstra_sssp_engine.sv
// Bench for dijkstra_sssp_engine with N_NODES=4.
// An Avalon slave model serves the matrix. It can add random waitrequest,
// readdatavalid latency and stray readdatavalid pulses.
// The expected distance words come from a path-length reference model.
module tb_dijkstra_sssp_engine;
  localparam int          N   = 4;
  localparam logic [31:0] INF = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset, start, stall;
  logic        busy, done, err;
  logic [63:0] graph, result;
  logic [31:0] src;
  logic [63:0] av_addr;
  logic [3:0]  av_be;
  logic        av_read, av_write, av_rdv, av_wait;
  logic [31:0] av_rdata, av_wdata;

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] exp_q[$];
  logic [63:0] exp_addr_q[$];
  logic        exp_err_q[$];
  logic [31:0] mem [logic [63:0]];
  logic [31:0] g [N][N];
  logic [31:0] ref_d [N];
  int          ref_reads;
  logic [63:0] cur_gb;
  int          rand_mode = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          done_cycles = 0;

  dijkstra_sssp_engine #(.N_NODES(N), .DIST_W(32), .ADDR_W(64)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .start                   (start),
    .busy                    (busy),
    .done                    (done),
    .stall                   (stall),
    .err                     (err),
    .graph                   (graph),
    .result                  (result),
    .src                     (src),
    .avmm_0_rw_address       (av_addr),
    .avmm_0_rw_byteenable    (av_be),
    .avmm_0_rw_read          (av_read),
    .avmm_0_rw_readdata      (av_rdata),
    .avmm_0_rw_readdatavalid (av_rdv),
    .avmm_0_rw_waitrequest   (av_wait),
    .avmm_0_rw_write         (av_write),
    .avmm_0_rw_writedata     (av_wdata)
  );

  // Clock and reset
  always #5 clock = ~clock;

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: got no completion, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Reference model: the shortest path length by relaxing every edge N times.
  // A length of INF or more counts as unreachable. Each reachable node is
  // expanded once. The i-th expansion reads every node not yet visited.
  task automatic compute_ref(input int s);
    longint d [N];
    longint big;
    longint w;
    int k;
    big = 64'h1_0000_0000;
    for (int v = 0; v < N; v++) d[v] = big;
    d[s] = 0;
    for (int it = 0; it < N; it++)
      for (int u = 0; u < N; u++)
        for (int v = 0; v < N; v++) begin
          w = longint'({32'h0, g[u][v]});
          if (u != v && w != 0 && d[u] < big && d[u] + w < d[v]) d[v] = d[u] + w;
        end
    k = 0;
    for (int v = 0; v < N; v++) begin
      if (d[v] >= longint'({32'h0, INF})) ref_d[v] = INF;
      else begin
        ref_d[v] = 32'(d[v]);
        k++;
      end
    end
    ref_reads = 0;
    for (int i = 0; i < k; i++) ref_reads += N - 1 - i;
  endtask

  task automatic clear_graph();
    for (int u = 0; u < N; u++)
      for (int v = 0; v < N; v++) g[u][v] = 32'h0;
  endtask

  task automatic load_graph(input logic [63:0] gb);
    for (int u = 0; u < N; u++)
      for (int v = 0; v < N; v++) mem[gb + 64'((u * N + v) * 4)] = g[u][v];
  endtask

  task automatic random_graph();
    int r;
    for (int u = 0; u < N; u++)
      for (int v = 0; v < N; v++) begin
        r = $urandom_range(0, 9);
        if (u == v)     g[u][v] = $urandom;
        else if (r < 4) g[u][v] = 32'h0;
        else if (r < 8) g[u][v] = $urandom_range(1, 30);
        else if (r == 8) g[u][v] = 32'hFFFF_FFE0 + $urandom_range(0, 15);
        else            g[u][v] = $urandom_range(100, 1000);
      end
  endtask

  // Avalon slave model plus monitor: serves reads, checks write words
  // against the expected queue, and takes each return.
  initial begin : bus_model
    bit          hold;
    logic        h_rd, h_wr;
    logic [63:0] h_addr;
    logic [31:0] h_data;
    int          pend;
    logic [63:0] pend_addr;
    logic [31:0] e_data;
    logic [63:0] e_addr;
    logic        e_err;
    hold = 1'b0;
    pend = 0;
    pend_addr = '0;
    av_wait = 1'b0;
    av_rdv = 1'b0;
    av_rdata = '0;
    forever begin
      @(negedge clock);
      av_rdv = 1'b0;
      if (reset) begin
        pend = 0;
        hold = 1'b0;
        av_wait = 1'b0;
      end else begin
        av_rdata = (rand_mode != 0) ? $urandom : 32'h0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            av_rdv = 1'b1;
            av_rdata = mem_rd(pend_addr);
          end
        end else if (rand_mode != 0 && $urandom_range(0, 7) == 0) begin
          av_rdv = 1'b1;
        end
        if (hold) begin
          check_eq("hold_read", av_read, h_rd);
          check_eq("hold_write", av_write, h_wr);
          check_eq("hold_addr", av_addr, h_addr);
          if (h_wr) check_eq("hold_wdata", av_wdata, h_data);
        end
        av_wait = (rand_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
        if (av_read || av_write) begin
          check_eq("rd_wr_exclusive", av_read && av_write, 1'b0);
          check_eq("byteenable", av_be, 4'hF);
        end
        if (av_read && !av_wait) begin
          check_eq("one_outstanding", pend, 0);
          check_eq("rd_addr_in_matrix",
                   (av_addr >= cur_gb) && (av_addr < cur_gb + 64'(N * N * 4)) &&
                   (av_addr[1:0] == 2'b00), 1'b1);
          pend = (rand_mode != 0) ? $urandom_range(1, 5) : 1;
          pend_addr = av_addr;
          rd_count++;
        end
        if (av_write && !av_wait) begin
          wr_count++;
          check_eq("wr_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e_data = exp_q.pop_front();
            e_addr = exp_addr_q.pop_front();
            check_eq("wr_data", av_wdata, e_data);
            check_eq("wr_addr", av_addr, e_addr);
          end
          mem[av_addr] = av_wdata;
        end
        hold = (av_read || av_write) && av_wait;
        h_rd = av_read;
        h_wr = av_write;
        h_addr = av_addr;
        h_data = av_wdata;
        if (done) begin
          done_cycles++;
          if (!stall) begin
            check_eq("ret_expected", exp_err_q.size() != 0, 1'b1);
            if (exp_err_q.size() != 0) begin
              e_err = exp_err_q.pop_front();
              check_eq("ret_err", err, e_err);
            end
          end
        end
      end
    end
  end

  // Driver: one call from start to the return. Entered and left at posedge+1 with busy=0.
  task automatic run_call(input logic [63:0] gb, input logic [63:0] rb,
                          input logic [31:0] s, input int stall_cyc);
    int rd0, wr0, dn0, t;
    load_graph(gb);
    cur_gb = gb;
    if (s < N) begin
      compute_ref(int'(s));
      for (int v = 0; v < N; v++) begin
        exp_q.push_back(ref_d[v]);
        exp_addr_q.push_back(rb + 64'(v * 4));
      end
      exp_err_q.push_back(1'b0);
    end else begin
      ref_reads = 0;
      exp_err_q.push_back(1'b1);
    end
    rd0 = rd_count;
    wr0 = wr_count;
    dn0 = done_cycles;
    start = 1'b1;
    graph = gb;
    result = rb;
    src = s;
    stall = (stall_cyc > 0);
    @(posedge clock); #1;
    start = 1'b0;
    graph = {$urandom, $urandom};
    result = {$urandom, $urandom};
    src = $urandom;
    check_eq("busy_after_start", busy, 1'b1);
    t = 0;
    while (!done && t < 5000) begin
      @(posedge clock); #1;
      t++;
    end
    check_eq("done_seen", done, 1'b1);
    if (done && stall_cyc > 0) begin
      for (int i = 0; i < stall_cyc; i++) begin
        check_eq("stall_done_held", done, 1'b1);
        check_eq("stall_busy_held", busy, 1'b1);
        start = i[0];
        @(posedge clock); #1;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    @(posedge clock); #1;
    check_eq("busy_released", busy, 1'b0);
    check_eq("done_released", done, 1'b0);
    check_eq("err_released", err, 1'b0);
    check_eq("read_count", 64'(rd_count - rd0), 64'(ref_reads));
    check_eq("write_count", 64'(wr_count - wr0), (s < N) ? 64'(N) : 64'(0));
    check_eq("done_cycles", 64'(done_cycles - dn0), 64'(stall_cyc + 1));
    check_eq("words_left", 64'(exp_q.size()), 64'(0));
    if (stall_cyc > 0) begin
      repeat (2) @(posedge clock);
      #1;
      check_eq("ignored_start_no_call", busy, 1'b0);
    end
    exp_q.delete();
    exp_addr_q.delete();
    exp_err_q.delete();
  endtask

  task automatic reset_mid_relax();
    int t;
    load_graph(64'h30);
    cur_gb = 64'h30;
    start = 1'b1;
    graph = 64'h30;
    result = 64'h300;
    src = 0;
    @(posedge clock); #1;
    start = 1'b0;
    t = 0;
    while (!av_read && t < 200) begin
      @(posedge clock); #1;
      t++;
    end
    check_eq("reached_relax", av_read, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_eq("abort_read", av_read, 1'b0);
    check_eq("abort_write", av_write, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check_eq("abort_stays_idle", busy, 1'b0);
  endtask

  // Stimulus sequence
  initial begin : stimulus
    logic [63:0] gb, rb;
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    graph = '0;
    result = '0;
    src = '0;
    cur_gb = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_read", av_read, 1'b0);
    check_eq("rst_write", av_write, 1'b0);
    check_eq("rst_address", av_addr, 64'h0);
    check_eq("rst_writedata", av_wdata, 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    clear_graph();
    g[0][1] = 32'd4;
    g[0][2] = 32'd1;
    g[2][1] = 32'd2;
    g[1][3] = 32'd5;
    run_call(64'h1000, 64'h2000, 0, 0);
    run_call(64'h1000, 64'h2000, 3, 0);
    run_call(64'h1000, 64'h2000, 5, 0);
    run_call(64'hA000_0000_0000_0100, 64'hB000_0000_0000_0040, 0, 0);

    clear_graph();
    g[0][1] = 32'hFFFF_FFF0;
    g[1][2] = 32'h20;
    run_call(64'h1000, 64'h2000, 0, 0);

    rand_mode = 1;
    clear_graph();
    g[0][1] = 32'd4;
    g[0][2] = 32'd1;
    g[2][1] = 32'd2;
    g[1][3] = 32'd5;
    run_call(64'h1000, 64'h2000, 0, 10);
    run_call(64'h1000, 64'h2000, 3, 0);

    for (int i = 0; i < 14; i++) begin
      random_graph();
      rand_mode = $urandom_range(0, 1);
      gb = {32'(i), 32'h1000 + 32'($urandom_range(0, 255) * 4)};
      rb = {32'(i), 32'h8000 + 32'($urandom_range(0, 255) * 4)};
      run_call(gb, rb, (i % 7 == 6) ? 32'($urandom_range(N, 300)) : 32'($urandom_range(0, N - 1)),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    rand_mode = 1;
    clear_graph();
    g[0][1] = 32'd4;
    g[0][2] = 32'd1;
    g[2][1] = 32'd2;
    g[1][3] = 32'd5;
    reset_mid_relax();

    rand_mode = 0;
    run_call(64'h1000, 64'h2000, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
